freespace_pkt_arbiter: RTL

Sits directly downstream of the leaf's input-port cluster and merges its per-port freespace (credit-return) packets into one packet stream toward the leaf's BFT egress. Each input port raises a one-cycle `freespace_update` pulse with its credit packet on its lane of `packet_from_input_ports`. This block captures every pulse, coalesces repeats from a port that is still pending, and round-robins the pending ports onto a single valid/ready output.

---
 rtl/bft_leaf_pkg.sv | 24 ++
 rtl/freespace_pkt_arbiter_if.sv | 35 +++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/freespace_pkt_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/bft_leaf_pkg.sv
// Shared constants for the BFT leaf blocks.
//   DEF_PACKET_BITS  : width of one BFT packet
//   DEF_NUM_IN_PORTS : input ports feeding credit packets
//   DEF_CNT_BITS     : width of the coalesce counter
//   idx_bits()       : width of a port index for a given port count
package bft_leaf_pkg;

  localparam int DEF_PACKET_BITS  = 97;
  localparam int DEF_NUM_IN_PORTS = 7;
  localparam int DEF_CNT_BITS     = 16;

  // Lane i occupies [DEF_LANE_BITS*(i+1)-1 : DEF_LANE_BITS*i] of the port bus.
  localparam int DEF_LANE_BITS    = DEF_PACKET_BITS;
  localparam int DEF_BUS_BITS     = DEF_PACKET_BITS * DEF_NUM_IN_PORTS;

  // A single-port build still needs a 1-bit index.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PORT_IDX_BITS = idx_bits(DEF_NUM_IN_PORTS);
  typedef logic [PORT_IDX_BITS-1:0] port_idx_t;

endpackage

// File: rtl/freespace_pkt_arbiter_if.sv
// Port-side and egress-side signals of the freespace packet arbiter.
//   freespace_update        : per-port capture strobe (one cycle)
//   packet_from_input_ports : concatenated per-port credit packets
//   out_packet/out_valid/out_ready/out_port_idx : egress handshake
//   coalesce_cnt            : saturating count of overwritten pending packets
//   idle                    : nothing pending and no packet presented
// slave modport = arbiter view, master modport = environment view.
interface freespace_pkt_arbiter_if
  import bft_leaf_pkg::*;
#(
  parameter int PACKET_BITS  = DEF_PACKET_BITS,
  parameter int NUM_IN_PORTS = DEF_NUM_IN_PORTS,
  parameter int CNT_BITS     = DEF_CNT_BITS
) ();
  localparam int IDX_W = idx_bits(NUM_IN_PORTS);

  logic [NUM_IN_PORTS-1:0]             freespace_update;
  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports;
  logic [PACKET_BITS-1:0]              out_packet;
  logic                                out_valid;
  logic                                out_ready;
  logic [IDX_W-1:0]                    out_port_idx;
  logic [CNT_BITS-1:0]                 coalesce_cnt;
  logic                                idle;

  modport slave (
    input  freespace_update, packet_from_input_ports, out_ready,
    output out_packet, out_valid, out_port_idx, coalesce_cnt, idle
  );

  modport master (
    output freespace_update, packet_from_input_ports, out_ready,
    input  out_packet, out_valid, out_port_idx, coalesce_cnt, idle
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker with its own rotating pointer.
//   req       : request vector
//   advance   : a grant is being taken this cycle; move the pointer past it
//   grant     : one-hot grant (first request at or above the pointer, wrapping)
//   grant_idx : encoded index of grant
//   any       : at least one request
module rr_arbiter
  import bft_leaf_pkg::*;
#(
  parameter int N     = DEF_NUM_IN_PORTS,
  parameter int IDX_W = idx_bits(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin : pick
    int cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        any         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance && any) begin
      rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/freespace_pkt_arbiter.sv
// Merges per-port freespace (credit-return) packets into one valid/ready
// stream. Each port has a capture register and a pending flag; a repeat
// strobe on a still-pending port overwrites the older packet and is counted.
//   clk   : BFT clock
//   reset : asynchronous active-low reset
//   bus   : freespace_pkt_arbiter_if.slave (strobes, lanes, egress handshake)
module freespace_pkt_arbiter
  import bft_leaf_pkg::*;
#(
  parameter int PACKET_BITS  = DEF_PACKET_BITS,
  parameter int NUM_IN_PORTS = DEF_NUM_IN_PORTS,
  parameter int CNT_BITS     = DEF_CNT_BITS
) (
  input logic                    clk,
  input logic                    reset,
  freespace_pkt_arbiter_if.slave bus
);
  localparam int IDX_W = idx_bits(NUM_IN_PORTS);
  localparam int POP_W = $clog2(NUM_IN_PORTS + 1);
  localparam int SUM_W = CNT_BITS + 1;

  logic [PACKET_BITS-1:0]  cap [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0] pend;
  logic [NUM_IN_PORTS-1:0] grant;
  logic [NUM_IN_PORTS-1:0] coalesce;
  logic [IDX_W-1:0]        grant_idx;
  logic                    any_pend;
  logic                    slot_free;
  logic                    do_grant;
  logic [PACKET_BITS-1:0]  grant_packet;
  logic [POP_W-1:0]        coalesce_pop;
  logic [SUM_W-1:0]        cnt_sum;
  logic [CNT_BITS-1:0]     cnt_next;

  logic [PACKET_BITS-1:0]  out_packet_q;
  logic                    out_valid_q;
  logic [IDX_W-1:0]        out_idx_q;
  logic [CNT_BITS-1:0]     cnt_q;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign do_grant  = slot_free && any_pend;

  rr_arbiter #(.N(NUM_IN_PORTS), .IDX_W(IDX_W)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (pend),
    .advance   (do_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_pend)
  );

  // A strobe on the port being granted this cycle just refills it; only a
  // strobe that would clobber an unsent packet counts as a coalesce.
  assign coalesce = bus.freespace_update & pend & ~({NUM_IN_PORTS{do_grant}} & grant);

  always_comb begin
    grant_packet = '0;
    coalesce_pop = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (grant[i]) grant_packet = grant_packet | cap[i];
      coalesce_pop = coalesce_pop + POP_W'(coalesce[i]);
    end
    cnt_sum  = {1'b0, cnt_q} + SUM_W'(coalesce_pop);
    cnt_next = cnt_sum[CNT_BITS] ? '1 : cnt_sum[CNT_BITS-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend         <= '0;
      out_packet_q <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < NUM_IN_PORTS; i++) cap[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (bus.freespace_update[i]) begin
          cap[i]  <= bus.packet_from_input_ports[PACKET_BITS*i +: PACKET_BITS];
          pend[i] <= 1'b1;
        end else if (do_grant && grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (slot_free) begin
        out_valid_q <= any_pend;
        if (any_pend) begin
          out_packet_q <= grant_packet;
          out_idx_q    <= grant_idx;
        end
      end
      cnt_q <= cnt_next;
    end
  end

  assign bus.out_packet   = out_packet_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_port_idx = out_idx_q;
  assign bus.coalesce_cnt = cnt_q;
  assign bus.idle         = ~|pend & ~out_valid_q;
endmodule
